gpu_global_mem: RTL

Parametrised GPU global memory with a multi-channel request front end, intended to sit inside the GPU card alongside the GPU die and serve its memory clients. Each of `NUM_CH` requesters presents a level-held read or write request. A round-robin arbiter grants one request at a time. The granted access completes after a fixed, configurable latency, with a one-cycle acknowledge back to the owning channel. The storage array is internal and is not cleared by reset.

---
 rtl/gpu_global_mem.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/gpu_global_mem.sv
// Multi-channel global memory: round-robin arbiter, fixed-latency access, one-cycle ack per channel.
// Define GPU_GLOBAL_MEM_BYTE_MASK_EN to add the per-byte write mask input ch_wr_mask.
module gpu_global_mem #(
  parameter int NUM_CH     = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ch_rd_req,
  input  logic [NUM_CH-1:0]            ch_wr_req,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wr_data,
`ifdef GPU_GLOBAL_MEM_BYTE_MASK_EN
  input  logic [NUM_CH*DATA_WIDTH/8-1:0] ch_wr_mask,
`endif
  output logic [NUM_CH-1:0]            ch_ack,
  output logic [NUM_CH*DATA_WIDTH-1:0] ch_rd_data,
  output logic                         busy
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int NB    = DATA_WIDTH / 8;
  localparam bit LAT1  = (LATENCY == 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [CH_W-1:0]         last_grant_reg;
  logic [CH_W-1:0]         gnt_ch_reg;
  logic                    gnt_wr_reg;
  logic [ADDR_WIDTH-1:0]   gnt_addr_reg;
  logic [DATA_WIDTH-1:0]   gnt_data_reg;
  logic [NB-1:0]           gnt_mask_reg;
  logic [NUM_CH-1:0]       ack_reg;
  logic                    busy_reg;
  logic [DATA_WIDTH-1:0]   rd_data_reg [NUM_CH];
  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

  logic [NUM_CH-1:0]       req;
  logic [ADDR_WIDTH-1:0]   addr_arr [NUM_CH];
  logic [DATA_WIDTH-1:0]   data_arr [NUM_CH];
  logic [NB-1:0]           mask_arr [NUM_CH];

  assign req = ch_rd_req | ch_wr_req;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign addr_arr[gi] = ch_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign data_arr[gi] = ch_wr_data[gi*DATA_WIDTH +: DATA_WIDTH];
`ifdef GPU_GLOBAL_MEM_BYTE_MASK_EN
      assign mask_arr[gi] = ch_wr_mask[gi*NB +: NB];
`else
      assign mask_arr[gi] = '1;
`endif
      assign ch_rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = rd_data_reg[gi];
    end
  endgenerate

  // Round-robin search starting just after the previous winner.
  logic            grant_valid;
  logic [CH_W-1:0] grant_ch;
  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant_ch    = '0;
    idx         = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last_grant_reg) + k) % NUM_CH;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_ch    = CH_W'(idx);
      end
    end
  end

  // With LATENCY=1 the access happens on the grant edge itself, so it uses the live inputs.
  logic                  acc_fire;
  logic [CH_W-1:0]       acc_ch;
  logic                  acc_wr;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_data;
  logic [NB-1:0]         acc_mask;

  assign acc_fire = LAT1 ? (state_reg == IDLE && grant_valid)
                         : (state_reg == BUSY && cnt_reg == CNT_W'(1));
  assign acc_ch   = LAT1 ? grant_ch            : gnt_ch_reg;
  assign acc_wr   = LAT1 ? ch_wr_req[grant_ch] : gnt_wr_reg;
  assign acc_addr = LAT1 ? addr_arr[grant_ch]  : gnt_addr_reg;
  assign acc_data = LAT1 ? data_arr[grant_ch]  : gnt_data_reg;
  assign acc_mask = LAT1 ? mask_arr[grant_ch]  : gnt_mask_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      last_grant_reg <= CH_W'(NUM_CH - 1);
      gnt_ch_reg     <= '0;
      gnt_wr_reg     <= 1'b0;
      gnt_addr_reg   <= '0;
      gnt_data_reg   <= '0;
      gnt_mask_reg   <= '0;
      ack_reg        <= '0;
      busy_reg       <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) rd_data_reg[c] <= '0;
    end else begin
      ack_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            state_reg      <= BUSY;
            busy_reg       <= 1'b1;
            cnt_reg        <= CNT_W'(LATENCY - 1);
            last_grant_reg <= grant_ch;
            gnt_ch_reg     <= grant_ch;
            gnt_wr_reg     <= ch_wr_req[grant_ch];
            gnt_addr_reg   <= addr_arr[grant_ch];
            gnt_data_reg   <= data_arr[grant_ch];
            gnt_mask_reg   <= mask_arr[grant_ch];
          end
        end
        BUSY: begin
          if (cnt_reg == '0) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
      // The storage update shares this block so an abandoned access never reaches the array.
      if (acc_fire) begin
        ack_reg[acc_ch] <= 1'b1;
        if (acc_wr) begin
          for (int b = 0; b < NB; b++)
            if (acc_mask[b]) mem[acc_addr][b*8 +: 8] <= acc_data[b*8 +: 8];
        end else begin
          rd_data_reg[acc_ch] <= mem[acc_addr];
        end
      end
    end
  end

  assign ch_ack = ack_reg;
  assign busy   = busy_reg;

endmodule
